// File: rtl/led_block_tx.sv
// led_block_tx: turns 60-bit block colour sums into 8-bit GRB pixels,
// queues them in a small FIFO and serialises them onto a WS2812-style strip.
// A latch gap is sent after every LED_COUNT pixels.
// Optional feature macro: LED_BRIGHT_EN adds a brightness scaling stage
// (a * BRIGHT) >> 8 after clamping, costing one extra pipeline cycle.

module led_block_tx #(
    parameter int BLOCK_PIXELS = 20,
    parameter int RECIP        = 3277,
    parameter int FIFO_DEPTH   = 16,
    parameter int LED_COUNT    = 64,
    parameter int BIT_CYCLES   = 93,
    parameter int T0H_CYCLES   = 30,
    parameter int T1H_CYCLES   = 59,
    parameter int RESET_CYCLES = 22275,
    parameter int BRIGHT       = 255
) (
    input  logic                          hdmi_clk,
    input  logic                          reset,
    input  logic                          channel_wire,
    input  logic [59:0]                   data,
    output logic                          led_dout,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(BIT_CYCLES);
    localparam int WW = $clog2(RESET_CYCLES + 1);
    localparam int PW = $clog2(LED_COUNT + 1);

    localparam logic [15:0]   RECIP_W    = 16'(RECIP);
    localparam logic [AW:0]   DEPTH_W    = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] CYC_LAST   = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] T0H_W      = CW'(T0H_CYCLES);
    localparam logic [CW-1:0] T1H_W      = CW'(T1H_CYCLES);
    localparam logic [WW-1:0] IDLE_LIMIT = WW'(RESET_CYCLES);
    localparam logic [WW-1:0] LATCH_LAST = WW'(RESET_CYCLES - 1);
    localparam logic [PW-1:0] PIX_LAST   = PW'(LED_COUNT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;
    localparam logic [1:0] ST_LATCH = 2'd3;

    // Parameter sanity checks evaluated at elaboration.
    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("led_block_tx: FIFO_DEPTH must be a power of two, at least 2");
        end
        if (RECIP * BLOCK_PIXELS < 65536) begin : g_bad_recip
            $error("led_block_tx: RECIP must be ceil(65536/BLOCK_PIXELS)");
        end
        if (BRIGHT < 0 || BRIGHT > 256) begin : g_bad_bright
            $error("led_block_tx: BRIGHT must lie in 0..256");
        end
    endgenerate

    // Divide one 20-bit sum by the block size via the reciprocal, clamped to 8 bits.
    function automatic logic [7:0] average(input logic [19:0] sum);
        logic [35:0] prod;
        logic [19:0] quot;
        prod = {16'd0, sum} * {20'd0, RECIP_W};
        quot = 20'(prod >> 16);
        return (|quot[19:8]) ? 8'hFF : quot[7:0];
    endfunction

    logic        chan_prev;
    logic        cap_valid;
    logic [59:0] cap_data;
    logic        avg_valid;
    logic [23:0] avg_word;
    logic        push_valid;
    logic [23:0] push_word;

    // Capture the block sum once per rising edge of the strobe.
    always_ff @(posedge hdmi_clk or posedge reset) begin
        if (reset) begin
            chan_prev <= 1'b0;
            cap_valid <= 1'b0;
            cap_data  <= '0;
        end else begin
            chan_prev <= channel_wire;
            cap_valid <= channel_wire & ~chan_prev;
            if (channel_wire && !chan_prev) begin
                cap_data <= data;
            end
        end
    end

    // Register the averaged, clamped GRB pixel.
    always_ff @(posedge hdmi_clk or posedge reset) begin
        if (reset) begin
            avg_valid <= 1'b0;
            avg_word  <= '0;
        end else begin
            avg_valid <= cap_valid;
            avg_word  <= {average(cap_data[59:40]), average(cap_data[39:20]),
                          average(cap_data[19:0])};
        end
    end

`ifdef LED_BRIGHT_EN
    localparam logic [8:0] BRIGHT_W = 9'(BRIGHT);

    // Apply the brightness multiplier to one 8-bit component.
    function automatic logic [7:0] scale(input logic [7:0] a);
        logic [16:0] prod;
        logic [8:0]  q;
        prod = {9'd0, a} * {8'd0, BRIGHT_W};
        q    = 9'(prod >> 8);
        return q[8] ? 8'hFF : q[7:0];
    endfunction

    logic        scl_valid;
    logic [23:0] scl_word;

    // Extra pipeline stage holding the brightness-scaled pixel.
    always_ff @(posedge hdmi_clk or posedge reset) begin
        if (reset) begin
            scl_valid <= 1'b0;
            scl_word  <= '0;
        end else begin
            scl_valid <= avg_valid;
            scl_word  <= {scale(avg_word[23:16]), scale(avg_word[15:8]), scale(avg_word[7:0])};
        end
    end

    assign push_valid = scl_valid;
    assign push_word  = scl_word;
`else
    assign push_valid = avg_valid;
    assign push_word  = avg_word;
`endif

    logic [23:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push_ok;
    logic        pop;
    logic [23:0] fifo_rd_data;
    logic [1:0]  state;

    assign fifo_level   = wr_ptr - rd_ptr;
    assign fifo_full    = (fifo_level == DEPTH_W);
    assign fifo_empty   = (wr_ptr == rd_ptr);
    assign push_ok      = push_valid & ~fifo_full;
    assign pop          = (state == ST_LOAD);
    assign fifo_rd_data = mem[rd_ptr[AW-1:0]];

    // FIFO storage; contents need no reset because the pointers gate them.
    always_ff @(posedge hdmi_clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_word;
        end
    end

    // FIFO pointers with an extra wrap bit, plus the sticky drop flag.
    always_ff @(posedge hdmi_clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_valid && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    logic [23:0]   shift_reg;
    logic [4:0]    bit_cnt;
    logic [CW-1:0] cyc_cnt;
    logic [CW-1:0] next_cyc;
    logic [CW-1:0] high_time;
    logic [WW-1:0] wait_cnt;
    logic [PW-1:0] pix_cnt;

    assign next_cyc  = cyc_cnt + 1'b1;
    assign high_time = shift_reg[23] ? T1H_W : T0H_W;
    assign busy      = (state != ST_IDLE);

    // Serialiser: load a pixel, send 24 pulse-width coded bits MSB first, latch per frame.
    always_ff @(posedge hdmi_clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            cyc_cnt   <= '0;
            wait_cnt  <= '0;
            pix_cnt   <= '0;
            led_dout  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    led_dout <= 1'b0;
                    if (!fifo_empty) begin
                        state <= ST_LOAD;
                    end
                    if (wait_cnt == IDLE_LIMIT) begin
                        pix_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_LOAD: begin
                    shift_reg <= fifo_rd_data;
                    bit_cnt   <= '0;
                    cyc_cnt   <= '0;
                    wait_cnt  <= '0;
                    led_dout  <= 1'b1;
                    state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (cyc_cnt == CYC_LAST) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == 5'd23) begin
                            led_dout <= 1'b0;
                            wait_cnt <= '0;
                            if (pix_cnt == PIX_LAST) begin
                                pix_cnt <= '0;
                                state   <= ST_LATCH;
                            end else begin
                                pix_cnt <= pix_cnt + 1'b1;
                                state   <= fifo_empty ? ST_IDLE : ST_LOAD;
                            end
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            shift_reg <= {shift_reg[22:0], 1'b0};
                            led_dout  <= 1'b1;
                        end
                    end else begin
                        cyc_cnt  <= next_cyc;
                        led_dout <= (next_cyc < high_time);
                    end
                end
                default: begin
                    led_dout <= 1'b0;
                    if (wait_cnt == LATCH_LAST) begin
                        wait_cnt <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_block_tx.sv
// tb_led_block_tx: scoreboard bench for led_block_tx.
// Expected pixel words are queued when strobes are driven; a monitor decodes
// the serial line and compares each received word against the queue head.
// Builds with or without LED_BRIGHT_EN.

module tb_led_block_tx;

    localparam int FIFO_DEPTH   = 4;
    localparam int LED_COUNT    = 2;
    localparam int BIT_CYCLES   = 93;
    localparam int T0H          = 30;
    localparam int T1H          = 59;
    localparam int RESET_CYCLES = 2000;
    localparam int BRIGHT       = 128;
`ifdef LED_BRIGHT_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        hdmi_clk = 1'b0;
    logic        reset;
    logic        channel_wire;
    logic [59:0] data;
    logic        led_dout;
    logic        busy;
    logic        overflow;
    logic [2:0]  fifo_level;

    int checks = 0;
    int errors = 0;
    logic [23:0] model_q[$];

    led_block_tx #(
        .BLOCK_PIXELS(20),
        .RECIP(3277),
        .FIFO_DEPTH(FIFO_DEPTH),
        .LED_COUNT(LED_COUNT),
        .BIT_CYCLES(BIT_CYCLES),
        .T0H_CYCLES(T0H),
        .T1H_CYCLES(T1H),
        .RESET_CYCLES(RESET_CYCLES),
        .BRIGHT(BRIGHT)
    ) dut (
        .hdmi_clk(hdmi_clk),
        .reset(reset),
        .channel_wire(channel_wire),
        .data(data),
        .led_dout(led_dout),
        .busy(busy),
        .overflow(overflow),
        .fifo_level(fifo_level)
    );

    always #5 hdmi_clk = ~hdmi_clk;

    // Block sums of 20*v average to exactly v for any 8-bit v.
    function automatic logic [59:0] make_data(input int g, input int r, input int b);
        return {20'(g * 20), 20'(r * 20), 20'(b * 20)};
    endfunction

    function automatic logic [23:0] exp_word(input int g, input int r, input int b);
`ifdef LED_BRIGHT_EN
        return {8'((g * BRIGHT) >> 8), 8'((r * BRIGHT) >> 8), 8'((b * BRIGHT) >> 8)};
`else
        return {8'(g), 8'(r), 8'(b)};
`endif
    endfunction

    task automatic monitor();
        int h;
        int nbits;
        logic prev;
        logic [23:0] w;
        logic [23:0] e;
        h = 0; nbits = 0; prev = 1'b0; w = '0;
        forever begin
            @(negedge hdmi_clk);
            if (reset) begin
                h = 0; nbits = 0; prev = 1'b0;
            end else begin
                if (led_dout === 1'b1) begin
                    h++;
                end else if (prev) begin
                    checks++;
                    if (h != T1H && h != T0H) begin
                        errors++;
                        $display("[TB] FAIL mon_high_time: got %0d cycles, want %0d or %0d", h, T0H, T1H);
                    end
                    w = {w[22:0], (h == T1H)};
                    nbits++;
                    h = 0;
                    if (nbits == 24) begin
                        nbits = 0;
                        checks++;
                        if (model_q.size() == 0) begin
                            errors++;
                            $display("[TB] FAIL mon_word: got unexpected word %06h, want none", w);
                        end else begin
                            e = model_q.pop_front();
                            if (w !== e) begin
                                errors++;
                                $display("[TB] FAIL mon_word: got %06h, want %06h", w, e);
                            end
                        end
                    end
                end
                prev = (led_dout === 1'b1);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge hdmi_clk);
        reset = 1'b1;
        channel_wire = 1'b0;
        repeat (3) @(negedge hdmi_clk);
        model_q.delete();
        reset = 1'b0;
        @(negedge hdmi_clk);
    endtask

    // Two-cycle strobe: high for one edge, low for the next.
    task automatic strobe(input logic [59:0] d, input logic [23:0] e, input bit accepted);
        @(negedge hdmi_clk);
        data = d;
        channel_wire = 1'b1;
        if (accepted) model_q.push_back(e);
        @(negedge hdmi_clk);
        channel_wire = 1'b0;
    endtask

    task automatic wait_rise(input int bound, input string tag, output bit ok);
        int n;
        n = 0;
        while (led_dout !== 1'b1 && n < bound) begin
            @(negedge hdmi_clk);
            n++;
        end
        checks++;
        ok = (led_dout === 1'b1);
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s_start: led_dout still %b after %0d cycles, want 1", tag, led_dout, bound);
        end
    endtask

    // Starts on the first high sample of a bit; returns high and busy-low durations.
    task automatic measure_bit(input int lmax, output int h, output int l);
        h = 0; l = 0;
        while (led_dout === 1'b1 && h < 200) begin
            h++;
            @(negedge hdmi_clk);
        end
        while (led_dout === 1'b0 && busy === 1'b1 && l < lmax) begin
            l++;
            @(negedge hdmi_clk);
        end
    endtask

    task automatic wait_queue_empty(input int bound, input string tag);
        int n;
        n = 0;
        while (model_q.size() != 0 && n < bound) begin
            @(negedge hdmi_clk);
            n++;
        end
        checks++;
        if (model_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_drain: %0d words outstanding after %0d cycles, want 0", tag, model_q.size(), bound);
        end
    endtask

    task automatic test_reset();
        logic [3:0] outs;
        bit saw_activity;
        $display("[TB] test_reset");
        repeat (2) @(negedge hdmi_clk);
        checks++;
        outs = {led_dout, busy, overflow, |fifo_level};
        if (outs !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_values: got dout/busy/ovf/level %b, want 0000", outs);
        end
        reset = 1'b0;
        @(negedge hdmi_clk);
        strobe(make_data(8'hC5, 8'h3A, 8'h91), exp_word(8'hC5, 8'h3A, 8'h91), 1'b1);
        strobe(make_data(8'h12, 8'h34, 8'h56), exp_word(8'h12, 8'h34, 8'h56), 1'b1);
        strobe(make_data(8'h78, 8'h9A, 8'hBC), exp_word(8'h78, 8'h9A, 8'hBC), 1'b1);
        strobe(make_data(8'hDE, 8'hF0, 8'h01), exp_word(8'hDE, 8'hF0, 8'h01), 1'b1);
        repeat (LAT) @(negedge hdmi_clk);
        checks++;
        if (fifo_level !== 3'd3 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_prefill: got level %0d busy %b, want level 3 busy 1", fifo_level, busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        outs = {led_dout, busy, overflow, |fifo_level};
        if (outs !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_midsend: got dout/busy/ovf/level %b (level %0d), want 0000", outs, fifo_level);
        end
        repeat (2) @(negedge hdmi_clk);
        model_q.delete();
        reset = 1'b0;
        saw_activity = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge hdmi_clk);
            if (led_dout !== 1'b0 || busy !== 1'b0 || fifo_level !== 3'd0) saw_activity = 1'b1;
        end
        checks++;
        if (saw_activity) begin
            errors++;
            $display("[TB] FAIL reset_stays_idle: got activity after reset release, want idle line");
        end
    endtask

    task automatic test_single_pixel();
        logic [23:0] w;
        int h, l;
        bit ok;
        $display("[TB] test_single_pixel");
        do_reset();
`ifdef LED_BRIGHT_EN
        w = 24'h7F3200;
`else
        w = 24'hFF6400;
`endif
        @(negedge hdmi_clk);
        data = {20'd5100, 20'd2000, 20'd0};
        channel_wire = 1'b1;
        model_q.push_back(w);
        @(negedge hdmi_clk);
        channel_wire = 1'b0;
        repeat (LAT - 1) @(negedge hdmi_clk);
        checks++;
        if (fifo_level !== 3'd0) begin
            errors++;
            $display("[TB] FAIL single_early_level: got %0d, want 0", fifo_level);
        end
        @(negedge hdmi_clk);
        checks++;
        if (fifo_level !== 3'd1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_write: got level %0d busy %b, want level 1 busy 0", fifo_level, busy);
        end
        @(negedge hdmi_clk);
        checks++;
        if (busy !== 1'b1 || led_dout !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_load: got busy %b dout %b, want busy 1 dout 0", busy, led_dout);
        end
        @(negedge hdmi_clk);
        wait_rise(1, "single", ok);
        if (ok) begin
            for (int b = 0; b < 24; b++) begin
                measure_bit(200, h, l);
                checks++;
                if (h != (w[23-b] ? T1H : T0H) || h + l != BIT_CYCLES) begin
                    errors++;
                    $display("[TB] FAIL single_bit%0d: got high %0d period %0d, want high %0d period %0d",
                             b, h, h + l, w[23-b] ? T1H : T0H, BIT_CYCLES);
                end
            end
        end
        wait_queue_empty(100, "single");
    endtask

    task automatic test_latch();
        logic [47:0] bits;
        int h, l, want_per;
        bit ok;
        $display("[TB] test_latch");
        do_reset();
        bits = {exp_word(8'hA5, 8'h0F, 8'hC3), exp_word(8'h3C, 8'hF1, 8'h5A)};
        strobe(make_data(8'hA5, 8'h0F, 8'hC3), bits[47:24], 1'b1);
        strobe(make_data(8'h3C, 8'hF1, 8'h5A), bits[23:0], 1'b1);
        wait_rise(50, "latch", ok);
        if (ok) begin
            for (int b = 0; b < 48; b++) begin
                measure_bit((b == 47) ? RESET_CYCLES + 200 : 200, h, l);
                want_per = (b == 23) ? BIT_CYCLES + 1 : (b == 47) ? BIT_CYCLES + RESET_CYCLES : BIT_CYCLES;
                checks++;
                if (h != (bits[47-b] ? T1H : T0H) || h + l != want_per) begin
                    errors++;
                    $display("[TB] FAIL latch_bit%0d: got high %0d period %0d, want high %0d period %0d",
                             b, h, h + l, bits[47-b] ? T1H : T0H, want_per);
                end
            end
            checks++;
            if (busy !== 1'b0 || led_dout !== 1'b0) begin
                errors++;
                $display("[TB] FAIL latch_end: got busy %b dout %b, want 0 0", busy, led_dout);
            end
        end
        wait_queue_empty(100, "latch");
    endtask

    task automatic test_overflow();
        int gs[6] = '{8'h81, 8'h0F, 8'hAA, 8'h7E, 8'hFF, 8'h11};
        int rs[6] = '{8'h12, 8'hF0, 8'h01, 8'hC3, 8'h00, 8'h22};
        int bs[6] = '{8'h34, 8'h55, 8'h80, 8'h3C, 8'h99, 8'h33};
        $display("[TB] test_overflow");
        do_reset();
        for (int i = 0; i < 6; i++) begin
            strobe(make_data(gs[i], rs[i], bs[i]), exp_word(gs[i], rs[i], bs[i]), i < 5);
        end
        repeat (LAT) @(negedge hdmi_clk);
        checks++;
        if (overflow !== 1'b1 || fifo_level !== 3'd4) begin
            errors++;
            $display("[TB] FAIL overflow_flag: got overflow %b level %0d, want 1 and 4", overflow, fifo_level);
        end
        wait_queue_empty(30000, "overflow");
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overflow_sticky: got %b, want 1", overflow);
        end
    endtask

    task automatic test_clamp();
        $display("[TB] test_clamp");
        do_reset();
        strobe({60{1'b1}}, exp_word(255, 255, 255), 1'b1);
        wait_queue_empty(3000, "clamp");
    endtask

    task automatic test_bright();
        $display("[TB] test_bright");
        do_reset();
        @(negedge hdmi_clk);
        data = {20'd5100, 20'd5100, 20'd5100};
        channel_wire = 1'b1;
`ifdef LED_BRIGHT_EN
        model_q.push_back(24'h7F7F7F);
`else
        model_q.push_back(24'hFFFFFF);
`endif
        @(negedge hdmi_clk);
        channel_wire = 1'b0;
        repeat (LAT - 1) @(negedge hdmi_clk);
        checks++;
        if (fifo_level !== 3'd0) begin
            errors++;
            $display("[TB] FAIL bright_early_level: got %0d, want 0", fifo_level);
        end
        @(negedge hdmi_clk);
        checks++;
        if (fifo_level !== 3'd1) begin
            errors++;
            $display("[TB] FAIL bright_write: got level %0d, want 1", fifo_level);
        end
        wait_queue_empty(3000, "bright");
    endtask

    initial begin
        reset = 1'b1;
        channel_wire = 1'b0;
        data = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_single_pixel();
        test_latch();
        test_overflow();
        test_clamp();
        test_bright();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
